// File: rtl/arm_exe_pkg.sv
// Shared encodings for the EXE stage: ALU commands, shifter types, NZCV bit positions
// and operand-forwarding selects.
package arm_exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_ID   = 2'b11;

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, 12-bit memory offset, or shifted Rm.
// Purely combinational.
module val2_gen
  import arm_exe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] val_rm,
  input  logic [11:0]   shift_operand,
  input  logic          imm,
  input  logic          mem_op,
  output logic [DW-1:0] val2
);

  logic signed [DW-1:0] rm_s;
  logic [4:0]           amt;

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input logic [4:0] n);
    logic [2*DW-1:0] d;
    d = {x, x} >> n;
    return d[DW-1:0];
  endfunction

  assign rm_s = val_rm;
  assign amt  = shift_operand[11:7];

  always_comb begin
    val2 = '0;
    if (imm) begin
      val2 = rotr({{(DW-8){1'b0}}, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_op) begin
      val2 = {{(DW-12){1'b0}}, shift_operand};
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << amt;
        SH_LSR:  val2 = val_rm >> amt;
        SH_ASR:  val2 = rm_s >>> amt;
        default: val2 = rotr(val_rm, amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// EXE stage: Val2 generation, ALU with NZCV status register, EXE/MEM pipeline register and
// combinational branch target. Define FORWARDING_EN to add operand-forwarding ports.
module exe_stage
  import arm_exe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FORWARDING_EN
  input  logic [1:0]    sel_src1,
  input  logic [1:0]    sel_src2,
  input  logic [DW-1:0] fwd_mem_val,
  input  logic [DW-1:0] fwd_wb_val,
`endif
  input  logic          freeze,
  input  logic [31:0]   pc_in,
  input  logic [DW-1:0] val_rn_in,
  input  logic [DW-1:0] val_rm_in,
  input  logic [3:0]    exe_cmd_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic          wb_enable_in,
  input  logic          branch_taken_in,
  input  logic          status_update_in,
  input  logic [3:0]    dest_reg_in,
  input  logic [11:0]   shift_operand_in,
  input  logic [23:0]   signed_imm_24_in,
  input  logic          imm_in,
  output logic          branch_taken_out,
  output logic [31:0]   branch_addr,
  output logic [3:0]    status_out,
  output logic [DW-1:0] alu_result_out,
  output logic [DW-1:0] store_val_out,
  output logic [3:0]    dest_reg_out,
  output logic          wb_enable_out,
  output logic          mem_read_out,
  output logic          mem_write_out
);

  logic signed [DW-1:0] rn_p0, rm_p0, val2_p0, res_p0;
  logic [DW-1:0]        val2_raw_p0;
  logic [DW:0]          sum_p0;
  logic                 c_p0, v_p0, flag_we_p0, c_in_p0;
  logic signed [31:0]   br_off_p0;

  logic [3:0]           status_p1;
  logic [DW-1:0]        alu_result_p1, store_val_p1;
  logic [3:0]           dest_reg_p1;
  logic                 wb_enable_p1, mem_read_p1, mem_write_p1;

  function automatic logic add_ovf(input logic signed [DW-1:0] a, b, r);
    return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [DW-1:0] a, b, r);
    return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  // ---- stage p0: operand select, Val2, ALU, branch target ----
`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      FWD_MEM: rn_p0 = fwd_mem_val;
      FWD_WB:  rn_p0 = fwd_wb_val;
      default: rn_p0 = val_rn_in;
    endcase
    case (sel_src2)
      FWD_MEM: rm_p0 = fwd_mem_val;
      FWD_WB:  rm_p0 = fwd_wb_val;
      default: rm_p0 = val_rm_in;
    endcase
  end
`else
  assign rn_p0 = val_rn_in;
  assign rm_p0 = val_rm_in;
`endif

  val2_gen #(.DW(DW)) u_val2_gen (
    .val_rm        (rm_p0),
    .shift_operand (shift_operand_in),
    .imm           (imm_in),
    .mem_op        (mem_read_in | mem_write_in),
    .val2          (val2_raw_p0)
  );

  assign val2_p0 = val2_raw_p0;
  assign c_in_p0 = status_p1[FLAG_C];

  always_comb begin
    sum_p0     = '0;
    res_p0     = '0;
    c_p0       = status_p1[FLAG_C];
    v_p0       = status_p1[FLAG_V];
    flag_we_p0 = 1'b1;
    case (exe_cmd_in)
      CMD_MOV: res_p0 = val2_p0;
      CMD_MVN: res_p0 = ~val2_p0;
      CMD_AND: res_p0 = rn_p0 & val2_p0;
      CMD_ORR: res_p0 = rn_p0 | val2_p0;
      CMD_EOR: res_p0 = rn_p0 ^ val2_p0;
      CMD_ADD, CMD_ADC: begin
        sum_p0 = {1'b0, rn_p0} + {1'b0, val2_p0}
               + {{DW{1'b0}}, (exe_cmd_in == CMD_ADC) & c_in_p0};
        res_p0 = sum_p0[DW-1:0];
        c_p0   = sum_p0[DW];
        v_p0   = add_ovf(rn_p0, val2_p0, res_p0);
      end
      CMD_SUB, CMD_SBC: begin
        // Two's-complement subtract: carry out is NOT borrow.
        sum_p0 = {1'b0, rn_p0} + {1'b0, ~val2_p0}
               + {{DW{1'b0}}, (exe_cmd_in == CMD_SUB) | c_in_p0};
        res_p0 = sum_p0[DW-1:0];
        c_p0   = sum_p0[DW];
        v_p0   = sub_ovf(rn_p0, val2_p0, res_p0);
      end
      default: flag_we_p0 = 1'b0;
    endcase
  end

  assign br_off_p0        = {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign branch_addr      = pc_in + br_off_p0;
  assign branch_taken_out = branch_taken_in;

  // ---- stage p1: status register and EXE/MEM register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_p1 <= '0;
    end else if (!freeze && status_update_in && flag_we_p0) begin
      status_p1 <= {res_p0[DW-1], (res_p0 == '0), c_p0, v_p0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_p1 <= '0;
      store_val_p1  <= '0;
      dest_reg_p1   <= '0;
      wb_enable_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
    end else if (!freeze) begin
      alu_result_p1 <= res_p0;
      store_val_p1  <= rm_p0;
      dest_reg_p1   <= dest_reg_in;
      wb_enable_p1  <= wb_enable_in;
      mem_read_p1   <= mem_read_in;
      mem_write_p1  <= mem_write_in;
    end
  end

  assign status_out     = status_p1;
  assign alu_result_out = alu_result_p1;
  assign store_val_out  = store_val_p1;
  assign dest_reg_out   = dest_reg_p1;
  assign wb_enable_out  = wb_enable_p1;
  assign mem_read_out   = mem_read_p1;
  assign mem_write_out  = mem_write_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: arithmetic reference model checked every cycle plus directed literal
// expectations. Define FORWARDING_EN to also exercise the forwarding ports.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0]  exe_cmd_in, dest_reg_in;
  logic        mem_read_in, mem_write_in, wb_enable_in, branch_taken_in, status_update_in, imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        branch_taken_out, wb_enable_out, mem_read_out, mem_write_out;
  logic [31:0] branch_addr, alu_result_out, store_val_out;
  logic [3:0]  status_out, dest_reg_out;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] fwd_mem_val, fwd_wb_val;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
`ifdef FORWARDING_EN
    .sel_src1         (sel_src1),
    .sel_src2         (sel_src2),
    .fwd_mem_val      (fwd_mem_val),
    .fwd_wb_val       (fwd_wb_val),
`endif
    .freeze           (freeze),
    .pc_in            (pc_in),
    .val_rn_in        (val_rn_in),
    .val_rm_in        (val_rm_in),
    .exe_cmd_in       (exe_cmd_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .wb_enable_in     (wb_enable_in),
    .branch_taken_in  (branch_taken_in),
    .status_update_in (status_update_in),
    .dest_reg_in      (dest_reg_in),
    .shift_operand_in (shift_operand_in),
    .signed_imm_24_in (signed_imm_24_in),
    .imm_in           (imm_in),
    .branch_taken_out (branch_taken_out),
    .branch_addr      (branch_addr),
    .status_out       (status_out),
    .alu_result_out   (alu_result_out),
    .store_val_out    (store_val_out),
    .dest_reg_out     (dest_reg_out),
    .wb_enable_out    (wb_enable_out),
    .mem_read_out     (mem_read_out),
    .mem_write_out    (mem_write_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                         input logic imm, input logic mem);
    logic [31:0] x;
    int n;
    if (imm) begin
      x = {24'd0, so[7:0]};
      n = 2 * int'(so[11:8]);
      repeat (n) x = {x[0], x[31:1]};
      return x;
    end
    if (mem) return {20'd0, so};
    x = rm;
    n = int'(so[11:7]);
    case (so[6:5])
      2'd0:    repeat (n) x = {x[30:0], 1'b0};
      2'd1:    repeat (n) x = {1'b0, x[31:1]};
      2'd2:    repeat (n) x = {x[31], x[31:1]};
      default: repeat (n) x = {x[0], x[31:1]};
    endcase
    return x;
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] st, output logic [31:0] res,
                                output logic [3:0] nst, output bit known);
    longint ua, ub, sa, sb, r, s, cin;
    bit arith, cout;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = longint'(st[1]);
    r = 0; s = 0; arith = 0; cout = 0; known = 1; res = 0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      4'd2: begin r = ua + ub; s = sa + sb; arith = 1; cout = (r > 64'sd4294967295); end
      4'd3: begin r = ua + ub + cin; s = sa + sb + cin; arith = 1; cout = (r > 64'sd4294967295); end
      4'd4: begin r = ua - ub; s = sa - sb; arith = 1; cout = (ua >= ub); end
      4'd5: begin r = ua - ub - (1 - cin); s = sa - sb - (1 - cin); arith = 1;
                  cout = (ua >= ub + (1 - cin)); end
      default: known = 0;
    endcase
    if (arith) res = r[31:0];
    nst = st;
    nst[3] = res[31];
    nst[2] = (res == 32'd0);
    if (arith) begin
      nst[1] = cout;
      nst[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  logic [31:0] e_alu, e_store;
  logic [3:0]  e_dest, e_status;
  logic [2:0]  e_ctl;

  always @(posedge clk or posedge rst) begin
    logic [31:0] a, b, r;
    logic [3:0]  ns;
    bit known;
    if (rst) begin
      e_alu = 0; e_store = 0; e_dest = 0; e_status = 0; e_ctl = 0;
    end else if (!freeze) begin
      a = val_rn_in;
      b = val_rm_in;
`ifdef FORWARDING_EN
      if (sel_src1 == 2'b01) a = fwd_mem_val; else if (sel_src1 == 2'b10) a = fwd_wb_val;
      if (sel_src2 == 2'b01) b = fwd_mem_val; else if (sel_src2 == 2'b10) b = fwd_wb_val;
`endif
      m_alu(exe_cmd_in, a, m_val2(b, shift_operand_in, imm_in, mem_read_in | mem_write_in),
            e_status, r, ns, known);
      if (status_update_in && known) e_status = ns;
      e_alu = r;
      e_store = b;
      e_dest = dest_reg_in;
      e_ctl = {wb_enable_in, mem_read_in, mem_write_in};
    end
  end

  always @(negedge clk) begin
    longint off;
    if (cmp_en) begin
      off = longint'(signed_imm_24_in);
      if (off >= 64'sd8388608) off = off - 64'sd16777216;
      check("alu_result", alu_result_out, e_alu);
      check("store_val", store_val_out, e_store);
      check("dest_reg", {28'd0, dest_reg_out}, {28'd0, e_dest});
      check("ctl", {29'd0, wb_enable_out, mem_read_out, mem_write_out}, {29'd0, e_ctl});
      check("status", {28'd0, status_out}, {28'd0, e_status});
      check("branch_taken", {31'd0, branch_taken_out}, {31'd0, branch_taken_in});
      check("branch_addr", branch_addr, 32'(longint'(pc_in) + off * 4));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic go(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                    input logic [11:0] so, input logic imm, input logic s,
                    input logic mr, input logic mw);
    exe_cmd_in = cmd; val_rn_in = rn; val_rm_in = rm; shift_operand_in = so;
    imm_in = imm; status_update_in = s; mem_read_in = mr; mem_write_in = mw;
    wb_enable_in = !mw; dest_reg_in = rn[3:0] ^ 4'h5;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu"}, alu_result_out, 32'd0);
    check({tag, "_store"}, store_val_out, 32'd0);
    check({tag, "_status"}, {28'd0, status_out}, 32'd0);
    check({tag, "_ctl"}, {24'd0, dest_reg_out, 1'b0, wb_enable_out, mem_read_out, mem_write_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; exe_cmd_in = 0;
    mem_read_in = 0; mem_write_in = 0; wb_enable_in = 0; branch_taken_in = 0;
    status_update_in = 0; dest_reg_in = 0; shift_operand_in = 0; signed_imm_24_in = 0;
    imm_in = 0; sel_src1 = 0; sel_src2 = 0; fwd_mem_val = 0; fwd_wb_val = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    cmp_en = 1'b1;

    go(4'b0010, 32'h7FFF_FFFF, 32'h0, 12'h001, 1, 1, 0, 0);
    check("adds_ovf_res", alu_result_out, 32'h8000_0000);
    check("adds_ovf_nzcv", {28'd0, status_out}, 32'h9);

    go(4'b0100, 32'd5, 32'h0, 12'h005, 1, 1, 0, 0);
    check("subs_eq_nzcv", {28'd0, status_out}, 32'h6);
    go(4'b0011, 32'd1, 32'h0, 12'h001, 1, 0, 0, 0);
    check("adc_cin", alu_result_out, 32'd3);

    go(4'b0001, 32'h0, 32'h0, 12'h4FF, 1, 0, 0, 0);
    check("imm_rot", alu_result_out, 32'hFF00_0000);
    go(4'b0001, 32'h0, 32'h8000_0000, 12'h240, 0, 0, 0, 0);
    check("asr4", alu_result_out, 32'hF800_0000);
    go(4'b0001, 32'h0, 32'h1234_5678, 12'h060, 0, 0, 0, 0);
    check("ror0", alu_result_out, 32'h1234_5678);
    go(4'b0001, 32'h0, 32'h1234_5678, 12'h460, 0, 0, 0, 0);
    check("ror8", alu_result_out, 32'h7812_3456);
    go(4'b0010, 32'd1, 32'h0000_00AB, 12'h200, 0, 1, 0, 0);
    go(4'b1001, 32'h0, 32'hF000_0000, 12'h0A0, 0, 1, 0, 0);
    go(4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 12'h000, 0, 1, 0, 0);
    go(4'b0111, 32'h0000_0000, 32'h0, 12'h000, 0, 1, 0, 0);
    go(4'b1000, 32'hAAAA_5555, 32'hFFFF_0000, 12'h000, 0, 1, 0, 0);

    go(4'b0100, 32'd3, 32'd5, 12'h000, 0, 1, 0, 0);
    check("subs_neg_res", alu_result_out, 32'hFFFF_FFFE);
    check("subs_neg_nzcv", {28'd0, status_out}, 32'h8);
    go(4'b0101, 32'd10, 32'd3, 12'h000, 0, 1, 0, 0);
    check("sbc_borrow_res", alu_result_out, 32'd6);
    check("sbc_borrow_nzcv", {28'd0, status_out}, 32'h2);
    go(4'b0100, 32'h8000_0000, 32'd1, 12'h000, 0, 1, 0, 0);

    go(4'b0010, 32'h1000, 32'hDEAD_BEEF, 12'h804, 0, 0, 0, 1);
    check("str_addr", alu_result_out, 32'h1804);
    check("str_data", store_val_out, 32'hDEAD_BEEF);
    go(4'b0010, 32'h2000, 32'h0, 12'hFFF, 0, 0, 1, 0);
    go(4'b1111, 32'h55, 32'h66, 12'h000, 0, 1, 0, 0);
    check("bad_cmd_res", alu_result_out, 32'd0);

    pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE; branch_taken_in = 1;
    #1;
    check("br_taken", {31'd0, branch_taken_out}, 32'd1);
    check("br_addr", branch_addr, 32'h0000_00F8);

    go(4'b0010, 32'd1, 32'h0, 12'h001, 1, 1, 0, 0);
    check("pre_freeze_nzcv", {28'd0, status_out}, 32'h0);
    freeze = 1;
    go(4'b0010, 32'h7FFF_FFFF, 32'h0, 12'h001, 1, 1, 0, 0);
    check("freeze_res", alu_result_out, 32'd2);
    check("freeze_nzcv", {28'd0, status_out}, 32'h0);
    pc_in = 32'h200; signed_imm_24_in = 24'h000001; branch_taken_in = 0;
    #1;
    check("freeze_br_addr", branch_addr, 32'h204);
    @(posedge clk);
    #1;
    freeze = 0;
    @(posedge clk);
    #1;
    check("unfreeze_res", alu_result_out, 32'h8000_0000);
    check("unfreeze_nzcv", {28'd0, status_out}, 32'h9);

    go(4'b1000, 32'h1234_0000, 32'h0000_5678, 12'h000, 0, 1, 0, 0);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst_hold");
    rst = 1'b0;

`ifdef FORWARDING_EN
    sel_src1 = 2'b01; fwd_mem_val = 32'd10;
    go(4'b0010, 32'd3, 32'h0, 12'h002, 1, 0, 0, 0);
    check("fwd_mem_rn", alu_result_out, 32'd12);
    sel_src1 = 2'b11; sel_src2 = 2'b10; fwd_wb_val = 32'hCAFE_0001;
    go(4'b0010, 32'd7, 32'h1, 12'h000, 0, 0, 0, 1);
    check("fwd_wb_store", store_val_out, 32'hCAFE_0001);
    sel_src2 = 2'b11;
    go(4'b0010, 32'd7, 32'h1, 12'h000, 0, 0, 0, 0);
    check("fwd_id_rm", alu_result_out, 32'd8);
    sel_src1 = 0; sel_src2 = 0;
`endif

    go(4'b0001, 32'h0, 32'h0, 12'h000, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
